// File: rtl/ball_paddle_engine.sv
// Ball/paddle game stage fed by the VGA timing generator: owns the paddle, ball and
// play state, updates them once per frame at the start of vertical blank, and paints RGB.
`timescale 1ns/1ps
module ball_paddle_engine #(
  parameter int PADDLE_W     = 64,
  parameter int PADDLE_H     = 8,
  parameter int PADDLE_Y     = 440,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int LOST_FRAMES  = 60
) (
  input  logic       VGA_clk,
  input  logic       rst_n,
  input  logic [9:0] xCount,
  input  logic [9:0] yCount,
  input  logic       displayArea,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       launch,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       ball_lost,
  output logic [1:0] play_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, LOST = 2'd2} state_t;

  localparam int CNT_W     = (LOST_FRAMES > 2) ? $clog2(LOST_FRAMES) : 1;
  localparam int PADDLE_X0 = (640 - PADDLE_W) / 2;
  localparam int GLUE_OFF  = PADDLE_W / 2 - BALL_SIZE / 2;

  localparam logic [10:0] PW   = 11'(PADDLE_W);
  localparam logic [10:0] PH   = 11'(PADDLE_H);
  localparam logic [10:0] PY   = 11'(PADDLE_Y);
  localparam logic [10:0] PS   = 11'(PADDLE_SPEED);
  localparam logic [10:0] BSZ  = 11'(BALL_SIZE);
  localparam logic [10:0] BS   = 11'(BALL_SPEED);
  localparam logic [10:0] PMAX = 11'(640 - PADDLE_W);
  localparam logic [10:0] BXMAX = 11'(640 - BALL_SIZE);
  localparam logic [10:0] BYLOST = 11'(480 - BALL_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOST_FRAMES - 1);

  state_t           state, stateNext;
  logic [9:0]       prevY;
  logic [9:0]       paddleX, paddleXNext;
  logic [9:0]       ballX, ballXNext, ballY, ballYNext;
  logic             dxRight, dxRightNext, dyDown, dyDownNext;
  logic [CNT_W-1:0] lostCnt, lostCntNext;
  logic             lostPulseNext, frameTick, paddleHit;
  logic [10:0]      x11, y11, px11, bx11, by11;
  logic             ballPix, paddlePix;
  logic [23:0]      rgbNext;

  assign x11  = {1'b0, xCount};
  assign y11  = {1'b0, yCount};
  assign px11 = {1'b0, paddleX};
  assign bx11 = {1'b0, ballX};
  assign by11 = {1'b0, ballY};

  assign frameTick = (prevY == 10'd479) && (yCount == 10'd480);
  assign paddleHit = dyDown && (by11 + BSZ <= PY) && (by11 + BSZ + BS >= PY) &&
                     (bx11 + BSZ > px11) && (bx11 < px11 + PW);

  always_comb begin
    stateNext     = state;
    paddleXNext   = paddleX;
    ballXNext     = ballX;
    ballYNext     = ballY;
    dxRightNext   = dxRight;
    dyDownNext    = dyDown;
    lostCntNext   = lostCnt;
    lostPulseNext = 1'b0;
    if (frameTick) begin
      if (btn_left && !btn_right)
        paddleXNext = (px11 < PS) ? 10'd0 : paddleX - 10'(PADDLE_SPEED);
      else if (btn_right && !btn_left)
        paddleXNext = (px11 + PS > PMAX) ? 10'(640 - PADDLE_W) : paddleX + 10'(PADDLE_SPEED);

      case (state)
        IDLE: begin
          ballXNext = paddleXNext + 10'(GLUE_OFF);
          ballYNext = 10'(PADDLE_Y - BALL_SIZE);
          if (launch) begin
            stateNext   = PLAY;
            dxRightNext = 1'b1;
            dyDownNext  = 1'b0;
          end
        end
        PLAY: begin
          if (!dxRight && bx11 < BS) begin
            ballXNext   = 10'd0;
            dxRightNext = 1'b1;
          end else if (dxRight && bx11 + BS > BXMAX) begin
            ballXNext   = 10'(640 - BALL_SIZE);
            dxRightNext = 1'b0;
          end else begin
            ballXNext = dxRight ? ballX + 10'(BALL_SPEED) : ballX - 10'(BALL_SPEED);
          end

          if (!dyDown && by11 < BS) begin
            ballYNext  = 10'd0;
            dyDownNext = 1'b1;
          end else if (paddleHit) begin
            ballYNext  = 10'(PADDLE_Y - BALL_SIZE);
            dyDownNext = 1'b0;
          end else begin
            ballYNext = dyDown ? ballY + 10'(BALL_SPEED) : ballY - 10'(BALL_SPEED);
          end

          if ({1'b0, ballYNext} >= BYLOST) begin
            stateNext     = LOST;
            lostCntNext   = '0;
            lostPulseNext = 1'b1;
          end
        end
        LOST: begin
          if (lostCnt == CNT_LAST) begin
            stateNext   = IDLE;
            lostCntNext = '0;
            ballXNext   = paddleXNext + 10'(GLUE_OFF);
            ballYNext   = 10'(PADDLE_Y - BALL_SIZE);
          end else begin
            lostCntNext = lostCnt + 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Pixel colour is judged against the positions held this cycle; it lands one clock later.
  always_comb begin
    ballPix   = (state != LOST) && (x11 >= bx11) && (x11 < bx11 + BSZ) &&
                (y11 >= by11) && (y11 < by11 + BSZ);
    paddlePix = (x11 >= px11) && (x11 < px11 + PW) && (y11 >= PY) && (y11 < PY + PH);
    rgbNext   = 24'h000040;
    if (!displayArea)   rgbNext = 24'h000000;
    else if (ballPix)   rgbNext = 24'hFFFFFF;
    else if (paddlePix) rgbNext = 24'h00FF00;
  end

  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      prevY     <= '0;
      state     <= IDLE;
      paddleX   <= 10'(PADDLE_X0);
      ballX     <= 10'(PADDLE_X0 + GLUE_OFF);
      ballY     <= 10'(PADDLE_Y - BALL_SIZE);
      dxRight   <= 1'b1;
      dyDown    <= 1'b0;
      lostCnt   <= '0;
      ball_lost <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else begin
      prevY     <= yCount;
      state     <= stateNext;
      paddleX   <= paddleXNext;
      ballX     <= ballXNext;
      ballY     <= ballYNext;
      dxRight   <= dxRightNext;
      dyDown    <= dyDownNext;
      lostCnt   <= lostCntNext;
      ball_lost <= lostPulseNext;
      {VGA_R, VGA_G, VGA_B} <= rgbNext;
    end
  end

  assign play_state = state;

endmodule

// File: tb/tb_ball_paddle_engine.sv
// Randomized scoreboard bench for ball_paddle_engine against an integer game model.
`timescale 1ns/1ps
module tb_ball_paddle_engine;

  logic       VGA_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] xCount = '0, yCount = '0;
  logic       displayArea = 1'b0, btn_left = 1'b0, btn_right = 1'b0, launch = 1'b0;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       ball_lost;
  logic [1:0] play_state;

  ball_paddle_engine dut (
    .VGA_clk(VGA_clk), .rst_n(rst_n), .xCount(xCount), .yCount(yCount),
    .displayArea(displayArea), .btn_left(btn_left), .btn_right(btn_right), .launch(launch),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .ball_lost(ball_lost), .play_state(play_state)
  );

  always #5 VGA_clk = ~VGA_clk;

  typedef struct {
    logic [23:0] rgb;
    logic [1:0]  st;
    logic        lost;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // game model: positions in plain integers, directions as +1/-1, state 0/1/2
  int mPad, mBx, mBy, mDx, mDy, mState, mCnt, mPrevY;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    mPad = 288; mBx = 316; mBy = 432; mDx = 1; mDy = -1;
    mState = 0; mCnt = 0; mPrevY = 0;
  endtask

  function automatic logic [23:0] modelPixel(input int x, input int y, input bit disp);
    if (!disp) return 24'h000000;
    if (mState != 2 && x >= mBx && x < mBx + 8 && y >= mBy && y < mBy + 8) return 24'hFFFFFF;
    if (x >= mPad && x < mPad + 64 && y >= 440 && y < 448) return 24'h00FF00;
    return 24'h000040;
  endfunction

  task automatic modelTick(input bit l, input bit r, input bit lch, output bit pulse);
    int oldPad, nx, ny;
    bit overlap;
    pulse = 0;
    oldPad = mPad;
    if (l && !r) mPad = (mPad - 4 < 0) ? 0 : mPad - 4;
    else if (r && !l) mPad = (mPad + 4 > 576) ? 576 : mPad + 4;
    case (mState)
      0: begin
        mBx = mPad + 28; mBy = 432;
        if (lch) begin mState = 1; mDx = 1; mDy = -1; end
      end
      1: begin
        if (mDx < 0 && mBx < 2) begin nx = 0; mDx = 1; end
        else if (mDx > 0 && mBx + 2 > 632) begin nx = 632; mDx = -1; end
        else nx = mBx + 2 * mDx;
        overlap = (mBx + 8 > oldPad) && (mBx < oldPad + 64);
        if (mDy < 0 && mBy < 2) begin ny = 0; mDy = 1; end
        else if (mDy > 0 && mBy + 8 <= 440 && mBy + 10 >= 440 && overlap) begin ny = 432; mDy = -1; end
        else ny = mBy + 2 * mDy;
        mBx = nx; mBy = ny;
        if (ny >= 472) begin mState = 2; mCnt = 0; pulse = 1; end
      end
      default: begin
        if (mCnt == 59) begin mState = 0; mCnt = 0; mBx = mPad + 28; mBy = 432; end
        else mCnt++;
      end
    endcase
  endtask

  task automatic cycle(input int x, input int y, input bit disp, input bit l, input bit r, input bit lch);
    exp_t e;
    bit pulse;
    @(negedge VGA_clk);
    xCount = 10'(x); yCount = 10'(y); displayArea = disp;
    btn_left = l; btn_right = r; launch = lch;
    e.rgb = modelPixel(x, y, disp);
    pulse = 0;
    if (mPrevY == 479 && y == 480) modelTick(l, r, lch, pulse);
    mPrevY = y;
    e.st = 2'(mState);
    e.lost = pulse;
    sb.push_back(e);
  endtask

  // one compressed frame: random probes (biased around the objects) then the 479->480 edge
  task automatic frame(input bit l, input bit r, input bit lch, input int probes);
    int x, y, k;
    for (int i = 0; i < probes; i++) begin
      k = int'($urandom_range(0, 2));
      if (k == 0) begin
        x = int'($urandom_range(0, 799)); y = int'($urandom_range(0, 524));
      end else if (k == 1) begin
        x = mBx - 2 + int'($urandom_range(0, 11)); y = mBy - 2 + int'($urandom_range(0, 11));
      end else begin
        x = mPad - 2 + int'($urandom_range(0, 67)); y = 438 + int'($urandom_range(0, 11));
      end
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      cycle(x, y, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
    end
    cycle(int'($urandom_range(0, 799)), 479, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    cycle(int'($urandom_range(0, 799)), 480, 1'b0, l, r, lch);
  endtask

  task automatic resetMid();
    @(negedge VGA_clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
    check("async_reset_state", {30'h0, play_state}, 32'h0);
    check("async_reset_lost", {31'h0, ball_lost}, 32'h0);
    yCount = '0; displayArea = 1'b0; btn_left = 1'b0; btn_right = 1'b0; launch = 1'b0;
    modelReset();
    @(negedge VGA_clk);
    @(negedge VGA_clk);
    rst_n = 1'b1;
  endtask

  task automatic trackFrames(input int n, input bit lch);
    bit l, r;
    for (int i = 0; i < n; i++) begin
      l = (mBx + 4 < mPad + 28);
      r = (mBx + 4 > mPad + 36);
      if ($urandom_range(0, 9) == 0) begin l = 1'($urandom); r = 1'($urandom); end
      frame(l, r, lch, 3);
    end
  endtask

  // monitor: every cycle the DUT presents a registered pixel/state; pop and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge VGA_clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, e.rgb});
        check("play_state", {30'h0, play_state}, {30'h0, e.st});
        check("ball_lost", {31'h0, ball_lost}, {31'h0, e.lost});
      end
    end
  end

  initial begin
    #5ms;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit reached;
    modelReset();
    repeat (3) @(negedge VGA_clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) frame(1'($urandom), 1'($urandom), 1'b0, 4);
    cycle(100, 300, 1'b1, 1'b0, 1'b0, 1'b0);
    resetMid();

    cycle(316, 432, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(290, 440, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(316, 432, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 80; i++) frame(1'b1, 1'b0, 1'b0, 3);
    for (int i = 0; i < 10; i++) frame(1'b1, 1'b1, 1'b0, 3);
    for (int i = 0; i < 160; i++) frame(1'b0, 1'b1, 1'b0, 3);

    frame(1'b0, 1'b0, 1'b1, 3);
    trackFrames(1500, 1'b1);
    for (int i = 0; i < 600; i++) frame(1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, 3);

    // steer the paddle away from the ball until the lost counter sits at 30
    reached = 0;
    for (int i = 0; i < 3000 && !reached; i++) begin
      frame(mBx >= 320, mBx < 320, 1'b1, 2);
      if (mState == 2 && mCnt == 30) reached = 1;
    end
    checks++;
    if (!reached) begin
      failures++;
      $display("FAIL reach_lost30 actual=state%0d_cnt%0d required=state2_cnt30", mState, mCnt);
    end
    resetMid();

    frame(1'b0, 1'b0, 1'b1, 3);
    trackFrames(200, 1'b1);

    repeat (3) @(negedge VGA_clk);
    check("scoreboard_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
